// File: rtl/io_bus_master_pkg.sv
// io_bus_master shared types.
// FSM states, IO_bus direction codes and abort status word.
package io_bus_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA_REQ,
      DATA_REL,
      STAT_REQ,
      STAT_REL,
      RESP
   } state_t;

   localparam logic        BUS_READ       = 1'b1;
   localparam logic        BUS_WRITE      = 1'b0;
   localparam logic [31:0] TIMEOUT_STATUS = 32'hFFFF_FFFF;

   // States in which the master waits on handshake_2
   function automatic logic is_wait(input state_t s);
      return s inside {DATA_REQ, DATA_REL, STAT_REQ, STAT_REL};
   endfunction

   // Wait states whose awaited handshake_2 level is high
   function automatic logic wants_ack(input state_t s);
      return s inside {DATA_REQ, STAT_REQ};
   endfunction

endpackage

// File: rtl/io_bus_master_timer.sv
// bus_timeout_timer: per-wait cycle counter.
// o_expired is high once TIMEOUT cycles have passed since clear.
module bus_timeout_timer #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] r_count;

   assign o_expired = (r_count == W'(TIMEOUT - 1));

   // Count enabled wait cycles, saturating at the expiry point
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/io_bus_master.sv
// io_bus_master: IO_bus initiator.
// Runs address, data and status handshake phases per command.
module io_bus_master
   import io_bus_master_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [DATA_W-1:0] rsp_status,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] bus_reg_address,
   output logic              bus_register_address_valid,
   output logic              bus_RW,
   output logic              bus_handshake_1,
   input  logic              bus_handshake_2,
   output logic [DATA_W-1:0] bus_data_out,
   input  logic [DATA_W-1:0] bus_data_in
);

   state_t            r_state;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_data;
   logic [DATA_W-1:0] r_rsp_status;
   logic              r_rsp_timeout;
   logic [ADDR_W-1:0] r_addr;
   logic              r_av;
   logic              r_rw;
   logic              r_h1;
   logic [DATA_W-1:0] r_dout;

   logic w_wait;
   logic w_level;
   logic w_hit;
   logic w_abort;
   logic w_tmr_clr;
   logic w_expired;

   assign w_wait    = is_wait(r_state);
   assign w_level   = wants_ack(r_state) ? bus_handshake_2
                                         : !bus_handshake_2;
   assign w_hit     = w_wait && w_level;
   assign w_abort   = w_wait && !w_level && w_expired;
   assign w_tmr_clr = (r_state == ADDR) || w_hit;

   bus_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_tmr_clr),
      .i_enable  (w_wait),
      .o_expired (w_expired)
   );

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_cmd_ready   <= !bus_handshake_2;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_status  <= '0;
         r_rsp_timeout <= 1'b0;
         r_addr        <= '0;
         r_av          <= 1'b0;
         r_rw          <= 1'b0;
         r_h1          <= 1'b0;
         r_dout        <= '0;
      end else if (w_abort) begin
         r_h1          <= 1'b0;
         r_av          <= 1'b0;
         r_dout        <= '0;
         r_rsp_timeout <= 1'b1;
         r_rsp_status  <= DATA_W'(TIMEOUT_STATUS);
         r_rsp_valid   <= 1'b1;
         r_state       <= RESP;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_cmd_ready <= !bus_handshake_2;
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready   <= 1'b0;
                  r_rsp_data    <= '0;
                  r_rsp_status  <= '0;
                  r_rsp_timeout <= 1'b0;
                  r_addr        <= cmd_addr;
                  r_av          <= 1'b1;
                  r_rw          <= cmd_rw;
                  r_dout        <= (cmd_rw == BUS_WRITE) ? cmd_data : '0;
                  r_state       <= ADDR;
               end
            end
            ADDR: begin
               r_h1    <= 1'b1;
               r_state <= DATA_REQ;
            end
            DATA_REQ: begin
               if (bus_handshake_2) begin
                  if (r_rw == BUS_READ) begin
                     r_rsp_data <= bus_data_in;
                  end
                  r_h1    <= 1'b0;
                  r_state <= DATA_REL;
               end
            end
            DATA_REL: begin
               if (!bus_handshake_2) begin
                  r_h1    <= 1'b1;
                  r_state <= STAT_REQ;
               end
            end
            STAT_REQ: begin
               if (bus_handshake_2) begin
                  r_rsp_status <= bus_data_in;
                  r_h1         <= 1'b0;
                  r_state      <= STAT_REL;
               end
            end
            STAT_REL: begin
               if (!bus_handshake_2) begin
                  r_av        <= 1'b0;
                  r_dout      <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= !bus_handshake_2;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready                  = r_cmd_ready;
   assign rsp_valid                  = r_rsp_valid;
   assign rsp_data                   = r_rsp_data;
   assign rsp_status                 = r_rsp_status;
   assign rsp_timeout                = r_rsp_timeout;
   assign bus_reg_address            = r_addr;
   assign bus_register_address_valid = r_av;
   assign bus_RW                     = r_rw;
   assign bus_handshake_1            = r_h1;
   assign bus_data_out               = r_dout;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: randomized bench with a responder model.
// Expected results come from transaction-level rules.
module tb_io_bus_master;

   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_rw = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [31:0] rsp_status;
   logic        rsp_timeout;
   logic [7:0]  bus_reg_address;
   logic        bus_register_address_valid;
   logic        bus_RW;
   logic        bus_handshake_1;
   logic        bus_handshake_2 = 1'b0;
   logic [31:0] bus_data_out;
   logic [31:0] bus_data_in = '0;

   io_bus_master #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .TIMEOUT (TO)
   ) dut (
      .clk                        (clk),
      .reset                      (reset),
      .cmd_valid                  (cmd_valid),
      .cmd_ready                  (cmd_ready),
      .cmd_rw                     (cmd_rw),
      .cmd_addr                   (cmd_addr),
      .cmd_data                   (cmd_data),
      .rsp_valid                  (rsp_valid),
      .rsp_ready                  (rsp_ready),
      .rsp_data                   (rsp_data),
      .rsp_status                 (rsp_status),
      .rsp_timeout                (rsp_timeout),
      .bus_reg_address            (bus_reg_address),
      .bus_register_address_valid (bus_register_address_valid),
      .bus_RW                     (bus_RW),
      .bus_handshake_1            (bus_handshake_1),
      .bus_handshake_2            (bus_handshake_2),
      .bus_data_out               (bus_data_out),
      .bus_data_in                (bus_data_in)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Responder: 0 = acks after ack_dly, 1 = never acks, 2 = stuck high
   int          mode = 0;
   int          ack_dly = 0;
   logic [31:0] rd_w = '0;
   logic [31:0] st_w = '0;
   logic        rclr = 1'b1;
   int          phase = 0;
   int          wcnt = 0;
   logic        held = 1'b0;

   // Registered responder following the two-phase handshake
   always @(posedge clk) begin
      if (rclr) begin
         bus_handshake_2 <= 1'b0;
         phase <= 0;
         wcnt  <= 0;
         held  <= 1'b0;
      end else if (mode == 2) begin
         bus_handshake_2 <= 1'b1;
         held <= 1'b0;
      end else if (mode == 1) begin
         bus_handshake_2 <= 1'b0;
      end else if (!bus_handshake_2 && bus_handshake_1) begin
         if (wcnt >= ack_dly) begin
            bus_handshake_2 <= 1'b1;
            bus_data_in <= (phase == 0) ? rd_w : st_w;
            held <= 1'b1;
            wcnt <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (bus_handshake_2 && !bus_handshake_1) begin
         bus_handshake_2 <= 1'b0;
         bus_data_in <= $urandom;
         held <= 1'b0;
         if (held) phase <= 1 - phase;
      end
   end

   logic [7:0]  ex_addr = '0;
   logic        ex_rw = 1'b0;
   logic [31:0] ex_dout = '0;
   int          hold_err = 0;
   int          h1_cyc = 0;

   // Bus-side monitor: request width and held address phase
   always @(negedge clk) begin
      if (bus_handshake_1) h1_cyc <= h1_cyc + 1;
      if (bus_register_address_valid &&
          (bus_reg_address !== ex_addr || bus_RW !== ex_rw ||
           bus_data_out !== ex_dout))
         hold_err <= hold_err + 1;
   end

   task automatic start_cmd(input logic rw, input logic [7:0] a,
                            input logic [31:0] d);
      int t = 0;
      ex_addr = a;
      ex_rw   = rw;
      ex_dout = rw ? 32'h0 : d;
      while (cmd_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("rdy_wait", 32'(t < 50), 32'd1);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = a;
      cmd_data  = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_data  = $urandom;
   endtask

   task automatic do_txn(input logic rw, input logic [7:0] a,
                         input logic [31:0] d, input logic [31:0] rdw,
                         input logic [31:0] stw, input int dly,
                         input int rdy_dly, input int md);
      int cyc = 0;
      int bad = 0;
      int he;
      int h1s;
      logic [31:0] sd;
      logic [31:0] ss;
      logic st;
      rd_w = rdw;
      st_w = stw;
      ack_dly = dly;
      mode = md;
      he = hold_err;
      start_cmd(rw, a, d);
      h1s = h1_cyc;
      while (rsp_valid !== 1'b1 && cyc < 200 + 4 * TO) begin
         @(posedge clk); #1; cyc++;
      end
      chk("rsp_wait", 32'(cyc < 200 + 4 * TO), 32'd1);
      if (md == 0) begin
         chk("latency", cyc + 1, 10 + 2 * dly);
         chk("rsp_data", rsp_data, rw ? rdw : 32'h0);
         chk("rsp_status", rsp_status, stw);
         chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
         chk("h1_width", h1_cyc - h1s, 2 * (2 + dly));
      end else begin
         chk("to_latency", cyc + 1, TO + 2);
         chk("to_data", rsp_data, 32'h0);
         chk("to_status", rsp_status, 32'hFFFF_FFFF);
         chk("to_flag", 32'(rsp_timeout), 32'd1);
         chk("to_h1_width", h1_cyc - h1s, TO);
      end
      chk("h1_low", 32'(bus_handshake_1), 32'd0);
      chk("av_low", 32'(bus_register_address_valid), 32'd0);
      chk("dout_low", bus_data_out, 32'h0);
      chk("addr_hold", hold_err - he, 0);
      sd = rsp_data;
      ss = rsp_status;
      st = rsp_timeout;
      repeat (rdy_dly) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_data !== sd ||
             rsp_status !== ss || rsp_timeout !== st ||
             cmd_ready !== 1'b0)
            bad++;
      end
      chk("rsp_stable", bad, 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      mode = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int t;
      int bad;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp", {29'd0, rsp_valid, rsp_timeout, bus_handshake_1},
          32'd0);
      chk("rst_bus", {23'd0, bus_register_address_valid, bus_reg_address},
          32'd0);
      reset = 1'b0;
      rclr  = 1'b0;
      @(posedge clk); #1;

      do_txn(1'b1, 8'h00, 32'h0, 32'h0001_0203, 32'hFFFE_FDFC, 0, 0, 0);
      do_txn(1'b0, 8'h05, 32'hDEAD_BEEF, $urandom, $urandom, 0, 1, 0);
      do_txn(1'b1, 8'h10, 32'h0, $urandom, $urandom, 0, 2, 1);
      do_txn(1'b0, 8'h22, $urandom, $urandom, $urandom, 1, 20, 0);

      for (int i = 0; i < 12; i++) begin
         do_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                $urandom, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 4), 0);
      end

      rd_w = 32'hA5A5_0001;
      st_w = 32'h0000_0042;
      ack_dly = 0;
      mode = 0;
      start_cmd(1'b1, 8'h3C, 32'h0);
      t = 0;
      while (!(bus_handshake_1 === 1'b0 && bus_handshake_2 === 1'b1) &&
             t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("rel_seen", 32'(t < 20), 32'd1);
      reset = 1'b1;
      rclr  = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      rclr  = 1'b0;
      chk("mid_rst_dout", bus_data_out, 32'h0);
      chk("mid_rst_ctl", {21'd0, bus_handshake_1, bus_RW,
          bus_register_address_valid, bus_reg_address}, 32'd0);
      chk("mid_rst_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
      chk("mid_rst_data", rsp_data, 32'h0);
      do_txn(1'b1, 8'h3C, 32'h0, 32'h1357_9BDF, 32'h2468_ACE0, 0, 0, 0);

      mode = 2;
      repeat (3) @(posedge clk);
      #1;
      chk("stuck_rdy", 32'(cmd_ready), 32'd0);
      ex_addr = 8'h77;
      ex_rw   = 1'b1;
      ex_dout = 32'h0;
      rd_w    = 32'hCAFE_F00D;
      st_w    = 32'h0000_0007;
      ack_dly = 0;
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_addr  = 8'h77;
      cmd_data  = 32'h0;
      bad = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (cmd_ready !== 1'b0 || bus_register_address_valid !== 1'b0)
            bad++;
      end
      chk("stuck_block", bad, 0);
      mode = 0;
      t = 0;
      while (bus_register_address_valid !== 1'b1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      cmd_valid = 1'b0;
      chk("release_accept", t, 3);
      t = 0;
      while (rsp_valid !== 1'b1 && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("post_stuck_data", rsp_data, 32'hCAFE_F00D);
      chk("post_stuck_status", rsp_status, 32'h0000_0007);
      chk("post_stuck_to", 32'(rsp_timeout), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
